// File: rtl/temp_mon_scan_pkg.sv
// Shared definitions for the temperature monitor scanner: FSM states and default parameters.
package temp_mon_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SETTLE,
    ST_CONV,
    ST_STORE
  } state_t;

  localparam int DEF_NCH      = 4;
  localparam int DEF_ADC_W    = 10;
  localparam int DEF_SCLK_DIV = 4;
  localparam int DEF_SETTLE   = 16;
  localparam int DEF_INTERVAL = 1000;
  localparam int DEF_HYST     = 4;

endpackage

// File: rtl/temp_mon_adc_rx.sv
// Serial ADC reader: one start pulse yields ADC_W SCLK pulses (SCLK_DIV low, SCLK_DIV high) with CS_N low,
// sampling SDO MSB-first on each SCLK rise; o_done is high in the final cycle, o_data valid from the next cycle.
module temp_mon_adc_rx
  import temp_mon_scan_pkg::*;
#(
  parameter int ADC_W    = DEF_ADC_W,
  parameter int SCLK_DIV = DEF_SCLK_DIV
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sdo,
  output logic             o_sclk,
  output logic             o_cs_n,
  output logic             o_done,
  output logic [ADC_W-1:0] o_data
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = (ADC_W > 1) ? $clog2(ADC_W) : 1;

  logic             r_busy;
  logic             r_sclk;
  logic [DIV_W-1:0] r_div;
  logic [BIT_W-1:0] r_bit;
  logic [ADC_W-1:0] r_shift;
  logic             w_half_end;
  logic             w_last_bit;

  assign w_half_end = (r_div == DIV_W'(SCLK_DIV - 1));
  assign w_last_bit = (r_bit == BIT_W'(ADC_W - 1));
  assign o_done     = r_busy && r_sclk && w_half_end && w_last_bit;
  assign o_sclk     = r_sclk;
  assign o_cs_n     = ~r_busy;
  assign o_data     = r_shift;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy  <= 1'b0;
      r_sclk  <= 1'b0;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else if (!r_busy) begin
      if (i_start) begin
        r_busy <= 1'b1;
        r_sclk <= 1'b0;
        r_div  <= '0;
        r_bit  <= '0;
      end
    end else if (!w_half_end) begin
      r_div <= r_div + DIV_W'(1);
    end else begin
      r_div <= '0;
      // SDO is captured on the same edge that raises SCLK
      if (!r_sclk) begin
        r_sclk  <= 1'b1;
        r_shift <= {r_shift[ADC_W-2:0], i_sdo};
      end else begin
        r_sclk <= 1'b0;
        if (w_last_bit) r_busy <= 1'b0;
        else            r_bit  <= r_bit + BIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/temp_mon_scan.sv
// Multiplexed temperature scanner: settle, convert and store each channel, then idle INTERVAL cycles.
// Scan takes NCH*(SETTLE+2*SCLK_DIV*ADC_W+1) cycles to SCAN_DONE; per-channel alarms with hysteresis.
module temp_mon_scan
  import temp_mon_scan_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int ADC_W    = DEF_ADC_W,
  parameter int SCLK_DIV = DEF_SCLK_DIV,
  parameter int SETTLE   = DEF_SETTLE,
  parameter int INTERVAL = DEF_INTERVAL,
  parameter int HYST     = DEF_HYST
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic [ADC_W-1:0]       i_thresh,
  input  logic                   i_alarm_clr,
  input  logic                   i_adc_sdo,
  output logic                   o_adc_sclk,
  output logic                   o_adc_cs_n,
  output logic [$clog2(NCH)-1:0] o_mux_sel,
  input  logic [$clog2(NCH)-1:0] i_rd_ch,
  output logic [ADC_W-1:0]       o_rd_data,
  output logic [NCH-1:0]         o_alarm,
  output logic                   o_scan_done
);

  localparam int CH_W  = $clog2(NCH);
  localparam int CNT_W = $clog2(((INTERVAL > SETTLE) ? INTERVAL : SETTLE) + 1);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  state_t           r_state;
  logic [CH_W-1:0]  r_ch;
  logic [CNT_W-1:0] r_cnt;
  logic             r_scan_done;
  logic [NCH-1:0]   r_alarm;
  logic [ADC_W-1:0] r_samples [NCH];

  logic             w_start;
  logic             w_done;
  logic [ADC_W-1:0] w_data;
  logic [ADC_W-1:0] w_lo;
  logic [NCH-1:0]   w_alarm_nxt;

  // Reset asserts asynchronously everywhere but releases two edges later
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_start = (r_state == ST_SETTLE) && (r_cnt == CNT_W'(SETTLE - 1));

  temp_mon_adc_rx #(
    .ADC_W    (ADC_W),
    .SCLK_DIV (SCLK_DIV)
  ) u_adc_rx (
    .i_clk   (i_clk),
    .i_rst_n (w_rst_n),
    .i_start (w_start),
    .i_sdo   (i_adc_sdo),
    .o_sclk  (o_adc_sclk),
    .o_cs_n  (o_adc_cs_n),
    .o_done  (w_done),
    .o_data  (w_data)
  );

  // Lower hysteresis bound saturates at 0 so a small threshold never clears
  assign w_lo = (i_thresh > ADC_W'(HYST)) ? (i_thresh - ADC_W'(HYST)) : '0;

  always_comb begin
    w_alarm_nxt = r_alarm;
    if (i_alarm_clr) w_alarm_nxt = '0;
    if (r_state == ST_STORE) begin
      if (w_data >= i_thresh)  w_alarm_nxt[r_ch] = 1'b1;
      else if (w_data < w_lo)  w_alarm_nxt[r_ch] = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_ch        <= '0;
      r_cnt       <= '0;
      r_scan_done <= 1'b0;
      r_alarm     <= '0;
      for (int i = 0; i < NCH; i++) r_samples[i] <= '0;
    end else begin
      r_scan_done <= 1'b0;
      r_alarm     <= w_alarm_nxt;
      case (r_state)
        ST_IDLE: begin
          if (i_enable) begin
            r_state <= ST_SETTLE;
            r_ch    <= '0;
            r_cnt   <= '0;
          end
        end
        ST_SETTLE: begin
          if (w_start) begin
            r_state <= ST_CONV;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_CONV: begin
          if (w_done) r_state <= ST_STORE;
        end
        ST_STORE: begin
          r_samples[r_ch] <= w_data;
          r_cnt           <= '0;
          if (r_ch == CH_W'(NCH - 1)) begin
            r_scan_done <= 1'b1;
            r_ch        <= '0;
            r_state     <= ST_WAIT;
          end else begin
            r_ch    <= r_ch + CH_W'(1);
            r_state <= ST_SETTLE;
          end
        end
        ST_WAIT: begin
          // ENABLE is only consulted here, so a dropped enable lets the scan finish
          if (r_cnt == CNT_W'(INTERVAL - 1)) begin
            r_cnt   <= '0;
            r_ch    <= '0;
            r_state <= i_enable ? ST_SETTLE : ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_mux_sel   = r_ch;
  assign o_alarm     = r_alarm;
  assign o_scan_done = r_scan_done;
  assign o_rd_data   = ({1'b0, i_rd_ch} < (CH_W + 1)'(NCH)) ? r_samples[i_rd_ch] : '0;

endmodule

// File: tb/tb_temp_mon_scan.sv
// Directed bench for temp_mon_scan with a serial ADC model driven from per-channel values.
module tb_temp_mon_scan;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       enable    = 1'b0;
  logic [9:0] thresh    = 10'h300;
  logic       alarm_clr = 1'b0;
  logic       adc_sdo   = 1'b0;
  logic [1:0] rd_ch     = 2'd0;
  logic       o_adc_sclk;
  logic       o_adc_cs_n;
  logic [1:0] o_mux_sel;
  logic [9:0] o_rd_data;
  logic [3:0] o_alarm;
  logic       o_scan_done;

  logic [9:0] adc_val [4];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_conv   = 0;
  int n_done   = 0;

  temp_mon_scan #(
    .NCH(4), .ADC_W(10), .SCLK_DIV(4), .SETTLE(16), .INTERVAL(1000), .HYST(4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_thresh    (thresh),
    .i_alarm_clr (alarm_clr),
    .i_adc_sdo   (adc_sdo),
    .o_adc_sclk  (o_adc_sclk),
    .o_adc_cs_n  (o_adc_cs_n),
    .o_mux_sel   (o_mux_sel),
    .i_rd_ch     (rd_ch),
    .o_rd_data   (o_rd_data),
    .o_alarm     (o_alarm),
    .o_scan_done (o_scan_done)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    logic prev_csn;
    prev_csn = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_csn === 1'b1 && o_adc_cs_n === 1'b0) n_conv++;
      prev_csn = o_adc_cs_n;
      if (o_scan_done === 1'b1) n_done++;
    end
  end

  // ADC model: presents the next bit after each SCLK rise, MSB first
  initial begin
    logic [9:0] adc_word;
    forever begin
      @(negedge o_adc_cs_n);
      adc_word = adc_val[o_mux_sel];
      for (int i = 9; i >= 0; i--) begin
        adc_sdo = adc_word[i];
        @(posedge o_adc_sclk or posedge o_adc_cs_n);
        if (o_adc_cs_n) break;
        #1;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got cycle %0d required finish", cyc);
    $fatal(1);
  end

  task automatic do_reset(input logic en);
    @(negedge clk);
    rst_n     = 1'b0;
    enable    = en;
    alarm_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int max, output bit ok, output int c);
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (o_scan_done === 1'b1) begin
        ok = 1'b1;
        c  = cyc;
        break;
      end
    end
  endtask

  task automatic wait_csn(input logic lvl, input int max, output bit ok, output int c);
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (o_adc_cs_n === lvl) begin
        ok = 1'b1;
        c  = cyc;
        break;
      end
    end
  endtask

  task automatic wait_state(input logic [1:0] ch, input logic csn, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (o_mux_sel === ch && o_adc_cs_n === csn) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (o_adc_cs_n !== 1'b1) $display("FAIL rst_cs_n: got %b exp 1", o_adc_cs_n); else n_pass++;
    n_checks++; if (o_adc_sclk !== 1'b0) $display("FAIL rst_sclk: got %b exp 0", o_adc_sclk); else n_pass++;
    n_checks++; if (o_mux_sel !== 2'd0) $display("FAIL rst_mux: got %0d exp 0", o_mux_sel); else n_pass++;
    n_checks++; if (o_scan_done !== 1'b0) $display("FAIL rst_done: got %b exp 0", o_scan_done); else n_pass++;
    n_checks++; if (o_alarm !== 4'b0000) $display("FAIL rst_alarm: got %b exp 0000", o_alarm); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      rd_ch = 2'(i);
      #1;
      n_checks++; if (o_rd_data !== 10'h000) $display("FAIL rst_rd ch%0d: got %h exp 000", i, o_rd_data); else n_pass++;
    end
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++; if (o_adc_cs_n !== 1'b1) $display("FAIL idle_no_conv: got cs_n %b exp 1", o_adc_cs_n); else n_pass++;
  endtask

  task automatic test_basic_scan();
    bit ok;
    int r0, c_fall, c_done, conv0, done0;
    for (int i = 0; i < 4; i++) adc_val[i] = 10'h200;
    thresh = 10'h300;
    do_reset(1'b1);
    r0 = cyc; conv0 = n_conv; done0 = n_done;
    wait_csn(1'b0, 100, ok, c_fall);
    n_checks++;
    if (!ok || (c_fall - r0) < 18 || (c_fall - r0) > 22)
      $display("FAIL first_conv_delay: got ok=%0d delay %0d exp 18..22", ok, c_fall - r0);
    else n_pass++;
    wait_done(1000, ok, c_done);
    n_checks++;
    if (!ok || (c_done - c_fall) != 372)
      $display("FAIL scan_latency: got ok=%0d %0d exp 372", ok, c_done - c_fall);
    else n_pass++;
    n_checks++; if (o_alarm !== 4'b0000) $display("FAIL basic_alarm: got %b exp 0000", o_alarm); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      rd_ch = 2'(i);
      #1;
      n_checks++; if (o_rd_data !== 10'h200) $display("FAIL basic_rd ch%0d: got %h exp 200", i, o_rd_data); else n_pass++;
    end
    repeat (5) @(negedge clk);
    n_checks++; if (n_done - done0 != 1) $display("FAIL basic_done_cnt: got %0d exp 1", n_done - done0); else n_pass++;
    n_checks++; if (n_conv - conv0 != 4) $display("FAIL basic_conv_cnt: got %0d exp 4", n_conv - conv0); else n_pass++;
  endtask

  task automatic test_alarm_hyst();
    bit ok;
    int c;
    for (int i = 0; i < 4; i++) adc_val[i] = 10'h200;
    adc_val[2] = 10'h310;
    thresh = 10'h300;
    do_reset(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (o_alarm !== 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok || o_alarm !== 4'b0100 || o_mux_sel !== 2'd3 || o_scan_done !== 1'b0)
      $display("FAIL alarm_set_at_store: got ok=%0d alarm %b mux %0d done %b exp 0100 mux 3 done 0",
               ok, o_alarm, o_mux_sel, o_scan_done);
    else n_pass++;
    wait_done(1000, ok, c);
    n_checks++; if (!ok || o_alarm !== 4'b0100) $display("FAIL alarm_scan1: got ok=%0d %b exp 0100", ok, o_alarm); else n_pass++;
    adc_val[2] = 10'h2FD;
    wait_done(2000, ok, c);
    n_checks++; if (!ok || o_alarm !== 4'b0100) $display("FAIL alarm_hold_2FD: got ok=%0d %b exp 0100", ok, o_alarm); else n_pass++;
    rd_ch = 2'd2;
    #1;
    n_checks++; if (o_rd_data !== 10'h2FD) $display("FAIL rd_ch2_2FD: got %h exp 2fd", o_rd_data); else n_pass++;
    adc_val[2] = 10'h2FB;
    wait_done(2000, ok, c);
    n_checks++; if (!ok || o_alarm !== 4'b0000) $display("FAIL alarm_clear_2FB: got ok=%0d %b exp 0000", ok, o_alarm); else n_pass++;
  endtask

  task automatic test_period_and_bounds();
    bit ok;
    int c1, c2, c3;
    adc_val[0] = 10'h300; adc_val[1] = 10'h305; adc_val[2] = 10'h001; adc_val[3] = 10'h001;
    thresh = 10'h300;
    do_reset(1'b1);
    wait_done(1000, ok, c1);
    n_checks++; if (!ok || o_alarm !== 4'b0011) $display("FAIL alarm_eq_thresh: got ok=%0d %b exp 0011", ok, o_alarm); else n_pass++;
    thresh = 10'h003;
    adc_val[0] = 10'h000; adc_val[1] = 10'h000;
    wait_done(2000, ok, c2);
    n_checks++; if (!ok || (c2 - c1) != 1388) $display("FAIL period1: got ok=%0d %0d exp 1388", ok, c2 - c1); else n_pass++;
    n_checks++; if (o_alarm !== 4'b0011) $display("FAIL alarm_sat_hold: got %b exp 0011", o_alarm); else n_pass++;
    wait_done(2000, ok, c3);
    n_checks++; if (!ok || (c3 - c2) != 1388) $display("FAIL period2: got ok=%0d %0d exp 1388", ok, c3 - c2); else n_pass++;
  endtask

  task automatic test_alarm_clr();
    bit ok;
    int c1, c_st, c;
    adc_val[0] = 10'h310; adc_val[1] = 10'h310; adc_val[2] = 10'h200; adc_val[3] = 10'h310;
    thresh = 10'h300;
    do_reset(1'b1);
    wait_done(1000, ok, c1);
    n_checks++; if (!ok || o_alarm !== 4'b1011) $display("FAIL clr_pre: got ok=%0d %b exp 1011", ok, o_alarm); else n_pass++;
    wait_state(2'd1, 1'b0, 2000, ok);
    if (ok) wait_csn(1'b1, 200, ok, c_st);
    n_checks++;
    if (!ok || c_st != c1 + 1193) $display("FAIL ch1_store_cycle: got ok=%0d %0d exp %0d", ok, c_st, c1 + 1193);
    else n_pass++;
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
    n_checks++; if (o_alarm !== 4'b0010) $display("FAIL clr_vs_store: got %b exp 0010", o_alarm); else n_pass++;
    wait_done(1000, ok, c);
    n_checks++; if (!ok || o_alarm !== 4'b1010) $display("FAIL clr_after_scan: got ok=%0d %b exp 1010", ok, o_alarm); else n_pass++;
  endtask

  task automatic test_reset_mid_conv();
    bit ok;
    int rises, c, conv0;
    logic ps;
    adc_val[0] = 10'h155; adc_val[1] = 10'h2AA; adc_val[2] = 10'h0F0; adc_val[3] = 10'h30F;
    thresh = 10'h3FF;
    rd_ch = 2'd0;
    do_reset(1'b1);
    wait_state(2'd1, 1'b0, 1000, ok);
    rises = 0;
    ps = o_adc_sclk;
    for (int i = 0; i < 200 && ok; i++) begin
      @(negedge clk);
      if (o_adc_sclk === 1'b1 && ps === 1'b0) rises++;
      ps = o_adc_sclk;
      if (rises == 5 && o_adc_sclk === 1'b0) break;
    end
    #1;
    n_checks++;
    if (!ok || rises != 5 || o_adc_cs_n !== 1'b0 || o_rd_data !== 10'h155)
      $display("FAIL pre_reset: got ok=%0d rises %0d cs_n %b rd %h exp rises 5 cs_n 0 rd 155",
               ok, rises, o_adc_cs_n, o_rd_data);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (o_adc_cs_n !== 1'b1) $display("FAIL rst_mid_cs_n: got %b exp 1", o_adc_cs_n); else n_pass++;
    n_checks++; if (o_adc_sclk !== 1'b0) $display("FAIL rst_mid_sclk: got %b exp 0", o_adc_sclk); else n_pass++;
    n_checks++; if (o_rd_data !== 10'h000) $display("FAIL rst_mid_rd0: got %h exp 000", o_rd_data); else n_pass++;
    adc_val[0] = 10'h0AB; adc_val[1] = 10'h1CD; adc_val[2] = 10'h2EF; adc_val[3] = 10'h123;
    repeat (3) @(negedge clk);
    conv0 = n_conv;
    rst_n = 1'b1;
    wait_csn(1'b0, 100, ok, c);
    n_checks++; if (!ok || o_mux_sel !== 2'd0) $display("FAIL restart_ch0: got ok=%0d mux %0d exp 0", ok, o_mux_sel); else n_pass++;
    wait_state(2'd1, 1'b0, 200, ok);
    rd_ch = 2'd1;
    #1;
    n_checks++; if (!ok || o_rd_data !== 10'h000) $display("FAIL no_stale_ch1: got ok=%0d %h exp 000", ok, o_rd_data); else n_pass++;
    wait_done(1000, ok, c);
    n_checks++; if (!ok) $display("FAIL restart_done: got timeout exp scan_done"); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      rd_ch = 2'(i);
      #1;
      n_checks++;
      if (o_rd_data !== adc_val[i]) $display("FAIL restart_rd ch%0d: got %h exp %h", i, o_rd_data, adc_val[i]);
      else n_pass++;
    end
    repeat (5) @(negedge clk);
    n_checks++; if (n_conv - conv0 != 4) $display("FAIL restart_conv_cnt: got %0d exp 4", n_conv - conv0); else n_pass++;
  endtask

  task automatic test_enable_drop();
    bit ok;
    int c, conv0, done0;
    for (int i = 0; i < 4; i++) adc_val[i] = 10'h200;
    thresh = 10'h300;
    do_reset(1'b1);
    conv0 = n_conv; done0 = n_done;
    wait_state(2'd1, 1'b1, 1000, ok);
    enable = 1'b0;
    wait_done(1000, ok, c);
    n_checks++; if (!ok) $display("FAIL en_drop_done: got timeout exp scan_done"); else n_pass++;
    repeat (1500) @(negedge clk);
    n_checks++; if (n_conv - conv0 != 4) $display("FAIL en_drop_conv: got %0d exp 4", n_conv - conv0); else n_pass++;
    n_checks++; if (n_done - done0 != 1) $display("FAIL en_drop_done_cnt: got %0d exp 1", n_done - done0); else n_pass++;
    n_checks++;
    if (o_adc_cs_n !== 1'b1 || o_mux_sel !== 2'd0)
      $display("FAIL en_drop_idle: got cs_n %b mux %0d exp 1 0", o_adc_cs_n, o_mux_sel);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_alarm_hyst();
    test_period_and_bounds();
    test_alarm_clr();
    test_reset_mid_conv();
    test_enable_drop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
